// File: rtl/frame_row_sequencer.sv
// Streams rows 0..LAST_ROW of a 256-bit row mux out as bytes, MSB byte first, with valid/ready handshake.
// Optional loop mode (continuous frames until STOP) is enabled by defining FRAME_SEQ_LOOP_EN.
module frame_row_sequencer #(
  parameter int LAST_ROW = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef FRAME_SEQ_LOOP_EN
  input  logic         stop,
`endif
  output logic [3:0]   address,
  input  logic [255:0] row,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  localparam logic [3:0] LAST = 4'(LAST_ROW);

  state_t         state;
  logic [255:0]   shreg;
  logic [4:0]     idx;

`ifdef FRAME_SEQ_LOOP_EN
  logic           stop_q;
  logic           stop_hit;

  // a stop arriving in the very cycle of the final transfer still ends the run
  assign stop_hit = stop_q | stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else if (state == IDLE || (state == FIN)) begin
      stop_q <= 1'b0;
    end else if (stop) begin
      stop_q <= 1'b1;
    end
  end
`endif

  assign byte_out = shreg[255:248];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      address    <= 4'd0;
      shreg      <= '0;
      idx        <= 5'd0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            address <= 4'd0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          shreg      <= row;
          idx        <= 5'd0;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (byte_ready) begin
            shreg <= shreg << 8;
            idx   <= idx + 5'd1;
            if (idx == 5'd31) begin
              byte_valid <= 1'b0;
              if (address != LAST) begin
                address <= address + 4'd1;
                state   <= LOAD;
              end else begin
`ifdef FRAME_SEQ_LOOP_EN
                // frame boundary: pulse done now, keep streaming from row 0 unless stopped
                done <= 1'b1;
                if (stop_hit) begin
                  state <= FIN;
                end else begin
                  address <= 4'd0;
                  state   <= LOAD;
                end
`else
                done  <= 1'b1;
                state <= FIN;
`endif
              end
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_row_sequencer.sv
// Randomized bench for frame_row_sequencer: reference stream is byte k = k mod 256 on row (k/32) mod 16.
// Also exercises a LAST_ROW=0 instance and, when FRAME_SEQ_LOOP_EN is defined, loop mode with STOP.
module tb_frame_row_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   address;
  logic [255:0] row;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         busy;
  logic         done;
`ifdef FRAME_SEQ_LOOP_EN
  logic         stop;
`endif

  logic         start_z;
  logic [3:0]   address_z;
  logic [255:0] row_z;
  logic [7:0]   byte_out_z;
  logic         byte_valid_z;
  logic         byte_ready_z;
  logic         busy_z;
  logic         done_z;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_row_sequencer #(.LAST_ROW(15)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FRAME_SEQ_LOOP_EN
    .stop(stop),
`endif
    .address(address), .row(row), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  frame_row_sequencer #(.LAST_ROW(0)) dut_z (
    .clk(clk), .rst(rst), .start(start_z),
`ifdef FRAME_SEQ_LOOP_EN
    .stop(1'b0),
`endif
    .address(address_z), .row(row_z), .byte_out(byte_out_z), .byte_valid(byte_valid_z),
    .byte_ready(byte_ready_z), .busy(busy_z), .done(done_z)
  );

  // row mux model: frame memory byte j holds j mod 256, row a is bytes 32a..32a+31, first byte at the top
  function automatic logic [255:0] row_model(input logic [3:0] a);
    logic [255:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) r[255-8*b -: 8] = 8'((32 * int'(a) + b) % 256);
    return r;
  endfunction

  always_comb row   = row_model(address);
  always_comb row_z = row_model(address_z);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // runs one start request; rst_at >= 0 resets the DUT while byte index rst_at is presented
  task automatic applyStimulus(input int ready_pct, input int frames, input bit glitch,
                               input int rst_at, input int stop_at);
    int k, done_count, last_done, cyc;
    logic pv, pr;
    logic [7:0] pb;
    logic [3:0] pa;
    bit finished;
    start = 1'b1;
    byte_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; k = 0; done_count = 0; last_done = 0;
    pv = 1'b0; pr = 1'b0; pb = 8'd0; pa = 4'd0;
    finished = 1'b0;
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_valid", 32'(byte_valid), 32'd0);
    for (int n = 0; n < 3000 && !finished; n++) begin
      if (done) begin
        done_count++;
        last_done = cyc;
      end
      if (pv && !pr) begin
        checkOutput("hold_byte", 32'(byte_out), 32'(pb));
        checkOutput("hold_addr", 32'(address), 32'(pa));
      end
      if (cyc == 2) checkOutput("first_valid", 32'(byte_valid), 32'd1);
      if (rst_at >= 0 && byte_valid && k == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_valid", 32'(byte_valid), 32'd0);
        checkOutput("rst_addr", 32'(address), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_byte", 32'(byte_out), 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          checkOutput("rst_nodone", 32'(done), 32'd0);
          checkOutput("rst_idle", 32'(busy), 32'd0);
        end
        return;
      end
      byte_ready = ($urandom_range(0, 99) < ready_pct);
      start = glitch && byte_valid && (k == 3 * 32 + 5);
`ifdef FRAME_SEQ_LOOP_EN
      stop = (cyc == stop_at);
`endif
      if (byte_valid && byte_ready) begin
        checkOutput("byte", 32'(byte_out), 32'(k % 256));
        checkOutput("row_addr", 32'(address), 32'((k / 32) % 16));
        k++;
      end
      pv = byte_valid; pr = byte_ready; pb = byte_out; pa = address;
      if (!busy) finished = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);
    checkOutput("byte_count", 32'(k), 32'(frames * 512));
    checkOutput("done_count", 32'(done_count), 32'(frames));
    if (ready_pct == 100) checkOutput("done_cycle", 32'(last_done), 32'(frames * 528 + 1));
    start = 1'b0;
    byte_ready = 1'b0;
`ifdef FRAME_SEQ_LOOP_EN
    stop = 1'b0;
`endif
  endtask

  initial begin
    int kz, dz;
    rst = 1'b1; start = 1'b0; byte_ready = 1'b0;
    start_z = 1'b0; byte_ready_z = 1'b0;
`ifdef FRAME_SEQ_LOOP_EN
    stop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(byte_valid), 32'd0);
    checkOutput("reset_addr", 32'(address), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_byte", 32'(byte_out), 32'd0);

    $display("[TB] full-rate frame");
    applyStimulus(100, 1, 1'b0, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] random backpressure frame with start during row 3");
    applyStimulus(50, 1, 1'b1, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset at row 7 byte 10, then fresh frame");
    applyStimulus(70, 1, 1'b0, 7 * 32 + 10, -1);
    applyStimulus(100, 1, 1'b0, -1, -1);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] LAST_ROW=0 instance");
    start_z = 1'b1; byte_ready_z = 1'b1;
    @(posedge clk); #1;
    start_z = 1'b0;
    kz = 0; dz = -1;
    for (int cyc = 1; cyc < 100 && busy_z; cyc++) begin
      if (done_z) dz = cyc;
      if (byte_valid_z) begin
        checkOutput("z_byte", 32'(byte_out_z), 32'(kz));
        checkOutput("z_addr", 32'(address_z), 32'd0);
        kz++;
      end
      @(posedge clk); #1;
    end
    checkOutput("z_count", 32'(kz), 32'd32);
    checkOutput("z_done_cycle", 32'(dz), 32'd34);
    checkOutput("z_idle", 32'(busy_z), 32'd0);

`ifdef FRAME_SEQ_LOOP_EN
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] loop mode with stop in second frame");
    applyStimulus(100, 2, 1'b0, -1, 700);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
